// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one combinational signed 32x32 multiplier
// between NUM_REQ requesters and returns tagged products over a valid/ready channel.

module mul_share_arbiter_mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  // Sign-extending both operands to 64 bits makes the low 64 product bits the signed result.
  assign p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
endmodule

module mul_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int MUL_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ID_W-1:0]       res_id,
  output logic [63:0]           res_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   id;
  logic [3:0]        cnt;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [63:0]       product;

  logic              grant_any;
  logic [ID_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;
  logic [ID_W-1:0]   ptr_next;

  function automatic int wrap_idx(input int base, input int offs);
    return (base + offs) % NUM_REQ;
  endfunction

  // op_a/op_b are frozen during CALC, so the multiplier gets MUL_CYCLES cycles to settle.
  mul_share_arbiter_mult u_mult (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  always_comb begin
    grant_any    = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    sel_a        = '0;
    sel_b        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && req_valid[wrap_idx(int'(ptr), k)]) begin
        grant_any                             = 1'b1;
        grant_idx                             = ID_W'(wrap_idx(int'(ptr), k));
        grant_onehot[wrap_idx(int'(ptr), k)]  = 1'b1;
        sel_a = req_a[32*wrap_idx(int'(ptr), k) +: 32];
        sel_b = req_b[32*wrap_idx(int'(ptr), k) +: 32];
      end
    end
  end

  assign ptr_next  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  // Gating with rst keeps a requester from seeing an accept that the reset edge would discard.
  assign req_ready = (state == IDLE && grant_any && !rst) ? grant_onehot : '0;
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (grant_any)  state_next = CALC;
      CALC: if (cnt == 4'd0) state_next = DONE;
      DONE: if (res_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      id       <= '0;
      ptr      <= '0;
      cnt      <= '0;
      res_data <= '0;
      res_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_a <= sel_a;
            op_b <= sel_b;
            id   <= grant_idx;
            ptr  <= ptr_next;
            cnt  <= 4'(MUL_CYCLES - 1);
          end
        end
        CALC: begin
          if (cnt == 4'd0) begin
            res_data <= product;
            res_id   <= id;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
